// File: rtl/conv_psum_requant.sv
// Requantisation stage behind the conv partial-sum accumulator: bias add, rounded
// arithmetic right shift, optional ReLU and saturation, in a two-stage valid/ready pipe.
module conv_psum_requant #(
    parameter int BITWIDTH_IN   = 24,
    parameter int BITWIDTH_BIAS = 16,
    parameter int BITWIDTH_OUT  = 8,
    parameter int LENGTH        = 4,
    parameter int SHIFT_W       = 5
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic [LENGTH*BITWIDTH_IN-1:0]    in_data,
    output logic                             in_ready,
    input  logic [LENGTH*BITWIDTH_BIAS-1:0]  bias,
    input  logic [SHIFT_W-1:0]               shift,
    input  logic                             relu_en,
    output logic                             out_valid,
    output logic [LENGTH*BITWIDTH_OUT-1:0]   out_data,
    input  logic                             out_ready,
    output logic [15:0]                      out_count
);
    localparam int SUM_W = BITWIDTH_IN + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (BITWIDTH_OUT - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (BITWIDTH_OUT - 1)));

    logic                            s1_valid_q, s1_valid_d;
    logic [LENGTH*SUM_W-1:0]         s1_sum_q, s1_sum_d;
    logic [SHIFT_W-1:0]              s1_shift_q, s1_shift_d;
    logic                            s1_relu_q, s1_relu_d;
    logic                            s2_valid_q, s2_valid_d;
    logic [LENGTH*BITWIDTH_OUT-1:0]  out_data_q, out_data_d;
    logic [15:0]                     out_count_q, out_count_d;

    logic                            s1_adv, s2_adv;
    logic signed [SUM_W-1:0]         rnd;
    logic [LENGTH*SUM_W-1:0]         lane_sum;
    logic [LENGTH*BITWIDTH_OUT-1:0]  lane_sat;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Very large shifts skip rounding so the result collapses to the sign (0 or -1).
    always_comb begin
        rnd = '0;
        if (shift != '0 && int'(shift) < SUM_W) begin
            rnd = SUM_W'(1) << (shift - SHIFT_W'(1));
        end
    end

    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_lane
        logic signed [SUM_W-1:0]  data_ext, bias_ext;
        logic signed [SUM_W-1:0]  sum_l, shifted, clipped;
        logic [BITWIDTH_OUT-1:0]  sat;

        assign data_ext = {{2{in_data[gi*BITWIDTH_IN+BITWIDTH_IN-1]}},
                           in_data[gi*BITWIDTH_IN +: BITWIDTH_IN]};
        assign bias_ext = {{(SUM_W-BITWIDTH_BIAS){bias[gi*BITWIDTH_BIAS+BITWIDTH_BIAS-1]}},
                           bias[gi*BITWIDTH_BIAS +: BITWIDTH_BIAS]};
        assign lane_sum[gi*SUM_W +: SUM_W] = data_ext + bias_ext + rnd;

        assign sum_l   = s1_sum_q[gi*SUM_W +: SUM_W];
        assign shifted = sum_l >>> s1_shift_q;

        always_comb begin
            clipped = shifted;
            if (s1_relu_q && shifted[SUM_W-1]) begin
                clipped = '0;
            end
            if (clipped > SAT_MAX) begin
                sat = SAT_MAX[BITWIDTH_OUT-1:0];
            end else if (clipped < SAT_MIN) begin
                sat = SAT_MIN[BITWIDTH_OUT-1:0];
            end else begin
                sat = clipped[BITWIDTH_OUT-1:0];
            end
        end

        assign lane_sat[gi*BITWIDTH_OUT +: BITWIDTH_OUT] = sat;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_shift_d  = s1_shift_q;
        s1_relu_d   = s1_relu_q;
        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        // Non-final passes are accepted (in_ready high) but never occupy stage 1.
        if (s1_adv) begin
            s1_valid_d = in_valid && in_last;
            if (in_valid && in_last) begin
                s1_sum_d   = lane_sum;
                s1_shift_d = shift;
                s1_relu_d  = relu_en;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = lane_sat;
            end
        end

        if (s2_valid_q && out_ready) begin
            out_count_d = out_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s1_relu_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_shift_q  <= s1_shift_d;
            s1_relu_q   <= s1_relu_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
endmodule

// File: tb/tb_conv_psum_requant.sv
// Bench for conv_psum_requant: directed and random beats scored against a queue-based
// arithmetic model of the requantisation and the two-slot pipeline occupancy.
module tb_conv_psum_requant;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_last, in_ready;
    logic [95:0] in_data;
    logic [63:0] bias;
    logic [4:0]  shift;
    logic        relu_en;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [15:0] out_count;

    conv_psum_requant dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .in_ready(in_ready), .bias(bias), .shift(shift),
        .relu_en(relu_en), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cur_d [4];
    int          cur_b [4];
    logic [31:0] exp_q [$];
    logic [15:0] exp_cnt = '0;
    bit          last_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_lane(input int x, input int b, input int s, input bit relu);
        longint v, n, d, q;
        v = longint'(x) + longint'(b);
        if (s == 0) begin
            q = v;
        end else if (s >= 26) begin
            q = (v < 0) ? -1 : 0;
        end else begin
            n = v + (longint'(1) << (s - 1));
            d = longint'(1) << s;
            q = n / d;
            if ((n % d) != 0 && n < 0) q = q - 1;
        end
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] r;
        int          y;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            y = ref_lane(cur_d[i], cur_b[i], int'(shift), relu_en);
            r[i*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    task automatic drive_beat();
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            t = cur_d[i];
            in_data[i*24 +: 24] = t[23:0];
            t = cur_b[i];
            bias[i*16 +: 16] = t[15:0];
        end
    endtask

    task automatic set_beat(input int d0, input int d1, input int d2, input int d3,
                            input int b0, input int b1, input int b2, input int b3,
                            input int s, input bit relu);
        cur_d[0] = d0; cur_d[1] = d1; cur_d[2] = d2; cur_d[3] = d3;
        cur_b[0] = b0; cur_b[1] = b1; cur_b[2] = b2; cur_b[3] = b3;
        shift = 5'(s);
        relu_en = relu;
        drive_beat();
    endtask

    task automatic rand_beat();
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1)
                cur_d[i] = int'($urandom_range(0, 16777215)) - 8388608;
            else
                cur_d[i] = int'($urandom_range(0, 2000)) - 1000;
            cur_b[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        shift = 5'($urandom_range(0, 31));
        relu_en = 1'($urandom_range(0, 1));
        drive_beat();
    endtask

    // One clock: score the cycle just before the edge, then check the count after it.
    task automatic tick();
        bit exp_rdy, acc, hs;
        #1;
        last_acc = 1'b0;
        if (rstn) begin
            exp_rdy = !(exp_q.size() == 2 && !out_ready);
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (out_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'd0);
                else check("out_data", 64'(out_data), 64'(exp_q[0]));
            end
            hs  = out_valid && out_ready && (exp_q.size() > 0);
            acc = in_valid && exp_rdy;
            if (hs) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (acc && in_last) exp_q.push_back(model_vec());
            last_acc = acc;
        end
        @(posedge clk);
        if (!rstn) begin
            exp_q.delete();
            exp_cnt = '0;
        end
        #1;
        check("out_count", 64'(out_count), 64'(exp_cnt));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_pulse();
        in_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int          n_acc;
        logic [15:0] c0;

        // Reset with a final beat already presented.
        rstn = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1;
        in_data = '0; bias = '0;
        set_beat(300, -300, 5, -5, 0, 0, 0, 0, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
        end
        rstn = 1'b1;
        tick();
        check("lat_accept_edge", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        tick();
        check("lat_two_cycles", 64'(out_valid), 64'd1);
        check("round_vec", 64'(out_data), 64'h00000000_FF01B54B);
        drain();

        // Saturation, ReLU and shift=0 pass-through.
        in_valid = 1'b1; in_last = 1'b1;
        set_beat(100000, -100000, 40, -40, 0, 0, 10, -10, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        drain();
        // Out-of-range shift collapses to the sign.
        in_valid = 1'b1;
        set_beat(-7, 7, -8388608, 8388607, 0, 0, -32768, 32767, 30, 1'b0);
        tick();
        in_valid = 1'b0;
        drain();

        // Non-final passes produce nothing.
        c0 = exp_cnt;
        in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            tick();
        end
        in_last = 1'b1;
        rand_beat();
        tick();
        drain();
        check("last_only_count", 64'(out_count), 64'(c0 + 16'd1));

        // Backpressure: six final beats with the consumer stalled for five cycles.
        reset_pulse();
        n_acc = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b1;
        rand_beat();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) begin
                n_acc++;
                rand_beat();
            end
        end
        check("stall_accepts", 64'(n_acc), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && n_acc < 6; i++) begin
            tick();
            if (last_acc) begin
                n_acc++;
                if (n_acc < 6) rand_beat();
            end
        end
        drain();
        check("stall_count", 64'(out_count), 64'd6);

        // Random traffic; an unaccepted beat is held until taken.
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            if (!in_valid || last_acc) begin
                in_valid = 1'($urandom_range(0, 2) != 0);
                in_last  = 1'($urandom_range(0, 3) != 0);
                rand_beat();
            end
            tick();
        end
        drain();

        // Counter wrap after 65536 deliveries.
        reset_pulse();
        n_acc = 0;
        in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        set_beat(1, 2, 3, 4, 0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 70000 && n_acc < 65536; i++) begin
            tick();
            if (last_acc) n_acc++;
        end
        drain();
        check("wrap_count", 64'(out_count), 64'd0);

        // Reset with two vectors in flight discards them.
        out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b1;
        n_acc = 0;
        rand_beat();
        for (int i = 0; i < 10 && n_acc < 2; i++) begin
            tick();
            if (last_acc) begin
                n_acc++;
                rand_beat();
            end
        end
        check("inflight_accepts", 64'(n_acc), 64'd2);
        in_valid = 1'b0;
        rstn = 1'b0;
        tick();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_output", 64'(out_valid), 64'd0);
        end
        check("midrst_count", 64'(out_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
